// File: rtl/ltc5548_sys_gpio_ctrl.sv
// LTC5548 system GPIO controller: WIDTH-bit output register with atomic
// set/clear and auto-clearing timed pulses, synchronised inputs with sticky
// edge capture, and a maskable level interrupt. Avalon-MM slave with zero
// wait states and read latency 0.
module ltc5548_sys_gpio_ctrl #(
   parameter int unsigned      WIDTH         = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
   parameter int unsigned      EDGE_TYPE     = 0,
   parameter logic [15:0]      PULSE_LEN_RST = 16'd100
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } pulse_state_e;

   localparam logic [2:0] A_DATA      = 3'd0;
   localparam logic [2:0] A_OUT       = 3'd1;
   localparam logic [2:0] A_IRQ_MASK  = 3'd2;
   localparam logic [2:0] A_EDGE_CAP  = 3'd3;
   localparam logic [2:0] A_OUTSET    = 3'd4;
   localparam logic [2:0] A_OUTCLR    = 3'd5;
   localparam logic [2:0] A_PULSE     = 3'd6;
   localparam logic [2:0] A_PULSE_LEN = 3'd7;

   logic [WIDTH-1:0] data_out_q,   data_out_d;
   logic [WIDTH-1:0] pulse_mask_q, pulse_mask_d;
   logic [WIDTH-1:0] irq_mask_q,   irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q,   edge_cap_d;
   logic [15:0]      cnt_q,        cnt_d;
   logic [15:0]      pulse_len_q,  pulse_len_d;
   logic [WIDTH-1:0] sync1_q, in_sync_q, in_d_q;
   logic             irq_q, irq_d;
   pulse_state_e     state_q, state_d;

   logic             wr_s;
   logic [WIDTH-1:0] wd_s;
   logic [WIDTH-1:0] rise_s, fall_s, sel_edge_s;
   logic [15:0]      reload_s;
   logic             unused_wd_s;

   assign wr_s        = chipselect & ~write_n;
   assign wd_s        = writedata[WIDTH-1:0];
   assign rise_s      = in_sync_q & ~in_d_q;
   assign fall_s      = ~in_sync_q & in_d_q;
   assign reload_s    = (pulse_len_q == 16'd0) ? 16'd1 : pulse_len_q;
   assign unused_wd_s = ^writedata;
   assign out_port    = data_out_q;
   assign irq         = irq_q;

   // Pick which synchronised edges are captured.
   always_comb begin
      case (EDGE_TYPE)
         32'd0:   sel_edge_s = rise_s;
         32'd1:   sel_edge_s = fall_s;
         32'd2:   sel_edge_s = rise_s | fall_s;
         default: sel_edge_s = rise_s;
      endcase
   end

   // Next-state logic: pulse expiry is applied first, then any bus write.
   always_comb begin
      data_out_d   = data_out_q;
      pulse_mask_d = pulse_mask_q;
      cnt_d        = cnt_q;
      state_d      = state_q;
      irq_mask_d   = irq_mask_q;
      edge_cap_d   = edge_cap_q;
      pulse_len_d  = pulse_len_q;

      if (state_q == ST_ACTIVE) begin
         if (cnt_q == 16'd1) begin
            data_out_d   = data_out_q & ~pulse_mask_q;
            pulse_mask_d = '0;
            cnt_d        = 16'd0;
            state_d      = ST_IDLE;
         end else begin
            cnt_d = cnt_q - 16'd1;
         end
      end else begin
         cnt_d = 16'd0;
      end

      if (wr_s) begin
         case (address)
            A_DATA: begin
               data_out_d   = wd_s;
               pulse_mask_d = '0;
               cnt_d        = 16'd0;
               state_d      = ST_IDLE;
            end
            A_IRQ_MASK:  irq_mask_d  = wd_s;
            A_EDGE_CAP:  edge_cap_d  = edge_cap_q & ~wd_s;
            A_OUTSET:    data_out_d  = data_out_d | wd_s;
            A_OUTCLR: begin
               data_out_d   = data_out_d & ~wd_s;
               pulse_mask_d = pulse_mask_d & ~wd_s;
            end
            A_PULSE: begin
               // An all-zero pulse only retriggers a pulse that is still running.
               if ((wd_s != '0) || (state_d == ST_ACTIVE)) begin
                  data_out_d   = data_out_d | wd_s;
                  pulse_mask_d = pulse_mask_d | wd_s;
                  cnt_d        = reload_s;
                  state_d      = ST_ACTIVE;
               end else begin
                  state_d = state_d;
               end
            end
            A_PULSE_LEN: pulse_len_d = writedata[15:0];
            default:     data_out_d  = data_out_d;
         endcase
      end else begin
         data_out_d = data_out_d;
      end

      // A new edge overrides a coincident write-one-to-clear.
      edge_cap_d = edge_cap_d | sel_edge_s;
      irq_d      = |(edge_cap_d & irq_mask_d);
   end

   // Combinational read mux, zero-extended above WIDTH.
   always_comb begin
      readdata = 32'd0;
      if (chipselect) begin
         case (address)
            A_DATA:      readdata[WIDTH-1:0] = in_sync_q;
            A_OUT:       readdata[WIDTH-1:0] = data_out_q;
            A_IRQ_MASK:  readdata[WIDTH-1:0] = irq_mask_q;
            A_EDGE_CAP:  readdata[WIDTH-1:0] = edge_cap_q;
            A_PULSE:     readdata[WIDTH-1:0] = pulse_mask_q;
            A_PULSE_LEN: readdata[15:0]      = pulse_len_q;
            default:     readdata            = 32'd0;
         endcase
      end else begin
         readdata = 32'd0;
      end
   end

   // All state: registers, pulse FSM, synchroniser and interrupt output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_q   <= RESET_VALUE;
         pulse_mask_q <= '0;
         irq_mask_q   <= '0;
         edge_cap_q   <= '0;
         cnt_q        <= 16'd0;
         pulse_len_q  <= PULSE_LEN_RST;
         sync1_q      <= '0;
         in_sync_q    <= '0;
         in_d_q       <= '0;
         irq_q        <= 1'b0;
         state_q      <= ST_IDLE;
      end else begin
         data_out_q   <= data_out_d;
         pulse_mask_q <= pulse_mask_d;
         irq_mask_q   <= irq_mask_d;
         edge_cap_q   <= edge_cap_d;
         cnt_q        <= cnt_d;
         pulse_len_q  <= pulse_len_d;
         sync1_q      <= in_port;
         in_sync_q    <= sync1_q;
         in_d_q       <= in_sync_q;
         irq_q        <= irq_d;
         state_q      <= state_d;
      end
   end

endmodule

// File: tb/tb_ltc5548_sys_gpio_ctrl.sv
// Directed testbench for ltc5548_sys_gpio_ctrl (WIDTH=8, RESET_VALUE=0xA5,
// rising-edge capture). Inputs change 1 ns after a rising edge; outputs are
// sampled in that same settled window.
module tb_ltc5548_sys_gpio_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic [7:0]  out_port;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;

   ltc5548_sys_gpio_ctrl #(
      .WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .PULSE_LEN_RST(16'd100)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .out_port(out_port), .irq(irq)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      step(1);
      chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
   endtask

   task automatic chk_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      #1;
      chk(tag, readdata, exp);
      chipselect = 1'b0;
   endtask

   initial begin
      reset_n = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'd0; in_port = 8'h00;
      #2 reset_n = 1'b0;
      #1 chk("rst_out_port", {24'd0, out_port}, 32'h0000_00A5);
      step(3);
      reset_n = 1'b1;
      step(1);

      // Reset state
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk_rd("rst_OUT", 3'd1, 32'h0000_00A5);
      chk_rd("rst_PULSE_LEN", 3'd7, 32'd100);
      chk_rd("rst_EDGE_CAP", 3'd3, 32'd0);
      chk_rd("rst_PULSE", 3'd6, 32'd0);
      address = 3'd1; #1 chk("rd_no_cs", readdata, 32'd0);

      // Output register: DATA, OUTSET, OUTCLR, OUT write ignored
      wr(3'd0, 32'hFFFF_FF0F);
      chk("data_wr", {24'd0, out_port}, 32'h0F);
      wr(3'd4, 32'h30);
      chk("outset", {24'd0, out_port}, 32'h3F);
      wr(3'd5, 32'h03);
      chk("outclr", {24'd0, out_port}, 32'h3C);
      chk_rd("rd_OUT", 3'd1, 32'h3C);
      chk_rd("rd_OUTSET_zero", 3'd4, 32'd0);
      wr(3'd1, 32'hFF);
      chk("out_wr_ignored", {24'd0, out_port}, 32'h3C);

      // Input sync and rising-edge capture latency
      in_port = 8'h5A;
      step(2);
      chk_rd("in_sync", 3'd0, 32'h5A);
      chk_rd("cap_not_yet", 3'd3, 32'h00);
      step(1);
      chk_rd("cap_3clk", 3'd3, 32'h5A);
      in_port = 8'h00;
      step(4);
      chk_rd("no_fall_cap", 3'd3, 32'h5A);
      chk("irq_masked", {31'd0, irq}, 32'd0);
      wr(3'd3, 32'hFF);
      chk_rd("cap_w1c_all", 3'd3, 32'h00);

      // Plain pulse, PULSE_LEN=5: high T+1..T+5, low T+6
      wr(3'd7, 32'd5);
      chk_rd("pulse_len_5", 3'd7, 32'd5);
      wr(3'd6, 32'h80);                      // now in T+1
      chk("p1_T1", {24'd0, out_port}, 32'hBC);
      chk_rd("p1_mask", 3'd6, 32'h80);
      step(4);                               // T+5
      chk("p1_T5", {24'd0, out_port}, 32'hBC);
      step(1);                               // T+6
      chk("p1_T6", {24'd0, out_port}, 32'h3C);
      chk_rd("p1_mask_done", 3'd6, 32'h00);

      // Retrigger at T+3 with 0x40; PULSE_LEN change mid-pulse has no effect
      wr(3'd6, 32'h80);                      // T+1
      step(2);                               // T+3
      wr(3'd6, 32'h40);                      // T+4
      chk_rd("rt_mask", 3'd6, 32'hC0);
      step(1);                               // T+5
      wr(3'd7, 32'd50);                      // T+6
      step(2);                               // T+8
      chk("rt_T8", {24'd0, out_port}, 32'hFC);
      step(1);                               // T+9
      chk("rt_T9", {24'd0, out_port}, 32'h3C);

      // Edge capture with interrupt
      wr(3'd2, 32'h01);
      chk_rd("irq_mask", 3'd2, 32'h01);
      in_port = 8'h01;
      step(2);
      chk("irq_not_yet", {31'd0, irq}, 32'd0);
      step(1);
      chk("irq_set", {31'd0, irq}, 32'd1);
      chk_rd("cap0", 3'd3, 32'h01);
      in_port = 8'h00;
      step(4);
      chk_rd("cap0_after_fall", 3'd3, 32'h01);
      wr(3'd3, 32'h01);
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      chk_rd("cap0_cleared", 3'd3, 32'h00);
      in_port = 8'h01;                       // cycle C
      step(2);                               // C+2: edge lands on W1C
      wr(3'd3, 32'h01);
      chk_rd("edge_beats_w1c", 3'd3, 32'h01);
      chk("irq_edge_beats_w1c", {31'd0, irq}, 32'd1);
      in_port = 8'h00;
      step(3);
      wr(3'd3, 32'h01);
      chk("irq_final_clear", {31'd0, irq}, 32'd0);

      // Expiry coinciding with OUTSET of the same bit, PULSE_LEN=3
      wr(3'd7, 32'd3);
      wr(3'd6, 32'h01);                      // T+1
      chk("ex_T1", {24'd0, out_port}, 32'h3D);
      step(2);                               // T+3: expiry cycle
      wr(3'd4, 32'h01);                      // T+4
      chk("ex_outset_keeps", {24'd0, out_port}, 32'h3D);
      chk_rd("ex_mask_zero", 3'd6, 32'h00);
      step(2);
      chk("ex_outset_stays", {24'd0, out_port}, 32'h3D);
      wr(3'd5, 32'h01);
      chk("ex_cleanup", {24'd0, out_port}, 32'h3C);

      // Expiry coinciding with a new PULSE write
      wr(3'd6, 32'h01);                      // T+1
      step(2);                               // T+3
      wr(3'd6, 32'h02);                      // T+4
      chk("exp_new_pulse", {24'd0, out_port}, 32'h3E);
      chk_rd("exp_new_mask", 3'd6, 32'h02);
      step(2);                               // T+6
      chk("exp_new_T6", {24'd0, out_port}, 32'h3E);
      step(1);                               // T+7
      chk("exp_new_T7", {24'd0, out_port}, 32'h3C);

      // DATA write mid-pulse cancels the pulse
      wr(3'd6, 32'h80);
      chk("dc_pulse_on", {24'd0, out_port}, 32'hBC);
      step(1);
      wr(3'd0, 32'h11);
      chk("dc_out", {24'd0, out_port}, 32'h11);
      chk_rd("dc_mask", 3'd6, 32'h00);
      step(5);
      chk("dc_out_held", {24'd0, out_port}, 32'h11);

      // Reset mid-pulse, PULSE_LEN=1000
      wr(3'd7, 32'd1000);
      wr(3'd6, 32'h02);
      chk("rp_pulse_on", {24'd0, out_port}, 32'h13);
      step(3);
      #2 reset_n = 1'b0;
      #1 chk("rp_async_out", {24'd0, out_port}, 32'hA5);
      step(2);
      reset_n = 1'b1;
      step(1);
      chk_rd("rp_mask", 3'd6, 32'h00);
      chk_rd("rp_len", 3'd7, 32'd100);
      wr(3'd6, 32'h00);                      // idle zero pulse: no-op
      step(5);
      chk("rp_out_held", {24'd0, out_port}, 32'hA5);
      chk_rd("rp_mask_idle", 3'd6, 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
